// File: rtl/psum_gb_arb_pkg.sv
// Shared types and sizes for the PSUM global-buffer write arbiter.
// Optional build macro used by the top: PSUM_GB_ARB_STAT_EN (per-channel stall counters).
package psum_gb_arb_pkg;

  localparam int PSUM_WIDTH = 20;
  localparam int LENROW     = 16;
  localparam int NUM_CH     = 3;
  localparam int ADDR_WIDTH = 10;
  localparam int LEN_WIDTH  = 10;
  localparam int BEAT_W     = PSUM_WIDTH * LENROW;
  localparam int CH_W       = 2;
  localparam int STAT_W     = 16;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Next channel index in round-robin order, wrapping 2 -> 0.
  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : (ch + 2'd1);
  endfunction

endpackage

// File: rtl/psum_gb_wr_arb_rr.sv
// Three-way round-robin arbiter: pick the first eligible channel at or after the pointer.
// Purely combinational; the pointer register lives in the parent.
module rr_arb_3
  import psum_gb_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] elig_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  logic [CH_W-1:0] cand_s [NUM_CH];

  // Candidate channel order starting from the pointer.
  always_comb begin
    cand_s[0] = ptr_i;
    for (int k = 1; k < NUM_CH; k++) begin
      cand_s[k] = rr_next(cand_s[k-1]);
    end
  end

  // Select the first eligible candidate and one-hot encode it.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any_o && elig_i[cand_s[k]]) begin
        any_o               = 1'b1;
        idx_o               = cand_s[k];
        grant_o[cand_s[k]]  = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/psum_gb_wr_arb.sv
// Merges the three PE-array psum channels into one GB psum write port.
// Round-robin grant, one registered output stage, per-channel address counters,
// start/done layer control. Define PSUM_GB_ARB_STAT_EN to add per-channel stall counters.
module psum_gb_wr_arb
  import psum_gb_arb_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  cfg_len,
  input  logic [NUM_CH-1:0]            psum_val,
  input  logic [NUM_CH*BEAT_W-1:0]     psum_data,
  output logic [NUM_CH-1:0]            psum_rdy,
  output logic                         gb_val,
  output logic [BEAT_W-1:0]            gb_data,
  output logic [ADDR_WIDTH-1:0]        gb_addr,
  output logic [CH_W-1:0]              gb_ch,
  input  logic                         gb_rdy,
  output logic                         busy,
  output logic                         done
`ifdef PSUM_GB_ARB_STAT_EN
  ,
  output logic [NUM_CH*STAT_W-1:0]     stat_stall
`endif
);

  state_t                state_q;
  logic                  done_q;
  logic [CH_W-1:0]       ptr_q;
  logic [ADDR_WIDTH-1:0] base_q [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_q  [NUM_CH];
  logic [LEN_WIDTH-1:0]  cnt_q  [NUM_CH];

  logic                  gb_val_q;
  beat_t                 gb_data_q;
  logic [ADDR_WIDTH-1:0] gb_addr_q;
  logic [CH_W-1:0]       gb_ch_q;

  logic [NUM_CH-1:0]     complete_s;
  logic [NUM_CH-1:0]     elig_s;
  logic [NUM_CH-1:0]     grant_s;
  logic [CH_W-1:0]       idx_s;
  logic                  any_s;
  logic                  all_done_s;
  logic                  free_s;
  logic                  xfer_s;
  beat_t                 sel_data_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;

  // Per-channel completion and arbitration eligibility; free when the output slot empties this cycle.
  always_comb begin
    complete_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      complete_s[i] = (cnt_q[i] == len_q[i]);
    end
    all_done_s = &complete_s;
    free_s     = !gb_val_q || gb_rdy;
    elig_s     = (state_q == RUN) ? (psum_val & ~complete_s) : '0;
  end

  rr_arb_3 u_arb (
    .elig_i  (elig_s),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (idx_s),
    .any_o   (any_s)
  );

  // Ready goes only to the granted channel, and only when the output slot can take a beat.
  always_comb begin
    psum_rdy = ((state_q == RUN) && free_s && any_s) ? grant_s : '0;
    xfer_s   = |(psum_val & psum_rdy);
  end

  // One-hot mux of the granted beat and its write address (base + beat count, wrapping).
  always_comb begin
    sel_data_s = '0;
    sel_addr_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data_s = sel_data_s | ({BEAT_W{grant_s[i]}} & psum_data[i*BEAT_W +: BEAT_W]);
      sel_addr_s = sel_addr_s | ({ADDR_WIDTH{grant_s[i]}} & (base_q[i] + ADDR_WIDTH'(cnt_q[i])));
    end
  end

  // Layer control FSM: config latch, beat counters, rr pointer and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (xfer_s) begin
        ptr_q <= rr_next(idx_s);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            for (int i = 0; i < NUM_CH; i++) begin
              base_q[i] <= cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH];
              len_q[i]  <= cfg_len[i*LEN_WIDTH +: LEN_WIDTH];
              cnt_q[i]  <= '0;
            end
          end
        end
        RUN: begin
          if (xfer_s) begin
            cnt_q[idx_s] <= cnt_q[idx_s] + LEN_WIDTH'(1'b1);
          end
          if (all_done_s) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!gb_val_q || gb_rdy) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register: load on a transfer, clear on pop, otherwise hold for the GB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gb_val_q  <= 1'b0;
      gb_data_q <= '0;
      gb_addr_q <= '0;
      gb_ch_q   <= '0;
    end else if (xfer_s) begin
      gb_val_q  <= 1'b1;
      gb_data_q <= sel_data_s;
      gb_addr_q <= sel_addr_s;
      gb_ch_q   <= idx_s;
    end else if (gb_rdy) begin
      gb_val_q  <= 1'b0;
    end
  end

  assign gb_val  = gb_val_q;
  assign gb_data = gb_data_q;
  assign gb_addr = gb_addr_q;
  assign gb_ch   = gb_ch_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

`ifdef PSUM_GB_ARB_STAT_EN
  logic [STAT_W-1:0] stall_q [NUM_CH];

  // Saturating per-channel count of RUN cycles where a channel offers data but is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stall_q[i] <= '0;
      end
    end else if ((state_q == IDLE) && start) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stall_q[i] <= '0;
      end
    end else if (state_q == RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (psum_val[i] && !psum_rdy[i] && (stall_q[i] != {STAT_W{1'b1}})) begin
          stall_q[i] <= stall_q[i] + STAT_W'(1'b1);
        end
      end
    end
  end

  // Pack counters onto the status port.
  always_comb begin
    stat_stall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stat_stall[i*STAT_W +: STAT_W] = stall_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_psum_gb_wr_arb.sv
// Scoreboard bench for psum_gb_wr_arb: per-channel expected beats are queued when a
// handshake is observed and popped when the GB port accepts a write.
module tb_psum_gb_wr_arb;
  import psum_gb_arb_pkg::*;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    beat_t                 data;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base = '0;
  logic [NUM_CH*LEN_WIDTH-1:0]  cfg_len = '0;
  logic [NUM_CH-1:0]            psum_val = '0;
  logic [NUM_CH*BEAT_W-1:0]     psum_data = '0;
  logic [NUM_CH-1:0]            psum_rdy;
  logic                         gb_val;
  logic [BEAT_W-1:0]            gb_data;
  logic [ADDR_WIDTH-1:0]        gb_addr;
  logic [CH_W-1:0]              gb_ch;
  logic                         gb_rdy = 1'b0;
  logic                         busy;
  logic                         done;
`ifdef PSUM_GB_ARB_STAT_EN
  logic [NUM_CH*STAT_W-1:0]     stat_stall;
`endif

  psum_gb_wr_arb dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .psum_val(psum_val), .psum_data(psum_data), .psum_rdy(psum_rdy),
    .gb_val(gb_val), .gb_data(gb_data), .gb_addr(gb_addr), .gb_ch(gb_ch),
    .gb_rdy(gb_rdy), .busy(busy), .done(done)
`ifdef PSUM_GB_ARB_STAT_EN
    , .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t pe;
  bit   have;

  int   lay_base [NUM_CH];
  int   lay_len  [NUM_CH];
  int   acc      [NUM_CH];
  bit   hs_seen  [NUM_CH];
  int   t_base   [NUM_CH];
  int   t_len    [NUM_CH];

  bit [NUM_CH-1:0] cur_val;
  beat_t           cur_data [NUM_CH];
  bit [NUM_CH-1:0] vmask;
  int  val_prob, rdy_prob, stall_start, stall_len, kcyc;
  bit  drop_after;

  bit  mon_en = 1'b0;
  int  cyc, busy_cyc, done_cyc, gbval_cyc, first_val, last_val, done_at;
  bit  done_seen;
  int  ch_log[$];
  bit  prev_stall;
  beat_t prev_data;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [CH_W-1:0] prev_ch;

  task automatic chk(input string name, input bit ok, input string got, input string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int w = 0; w < BEAT_W / 32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: scoreboard pops on GB writes, pushes on channel handshakes, protocol checks.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        done_at = cyc;
        done_seen = 1'b1;
      end
      if (gb_val) begin
        gbval_cyc++;
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
      end
      if (prev_stall)
        chk("hold_stable", gb_val && gb_data == prev_data && gb_addr == prev_addr && gb_ch == prev_ch,
            $sformatf("val=%0d addr=%0d ch=%0d", gb_val, gb_addr, gb_ch),
            $sformatf("val=1 addr=%0d ch=%0d", prev_addr, prev_ch));
      prev_stall = gb_val && !gb_rdy;
      prev_data = gb_data;
      prev_addr = gb_addr;
      prev_ch = gb_ch;
      chk("rdy_onehot", $countones(psum_rdy) <= 1, $sformatf("%b", psum_rdy), "at most one bit");
      if (gb_val && !gb_rdy)
        chk("rdy_low_stall", psum_rdy == '0, $sformatf("%b", psum_rdy), "000");
      if (gb_val && gb_rdy) begin
        have = 1'b0;
        case (gb_ch)
          2'd0: if (q0.size() > 0) begin pe = q0.pop_front(); have = 1'b1; end
          2'd1: if (q1.size() > 0) begin pe = q1.pop_front(); have = 1'b1; end
          2'd2: if (q2.size() > 0) begin pe = q2.pop_front(); have = 1'b1; end
          default: have = 1'b0;
        endcase
        chk("sb_expected_beat", have, $sformatf("write on ch%0d", gb_ch), "a pending beat");
        if (have)
          chk("sb_beat", gb_addr == pe.addr && gb_data == pe.data,
              $sformatf("ch%0d addr=%0d data=%h", gb_ch, gb_addr, gb_data),
              $sformatf("addr=%0d data=%h", pe.addr, pe.data));
        ch_log.push_back(int'(gb_ch));
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (psum_val[i] && psum_rdy[i]) begin
          pe.addr = ADDR_WIDTH'((lay_base[i] + acc[i]) % 1024);
          pe.data = cur_data[i];
          if (i == 0) q0.push_back(pe);
          else if (i == 1) q1.push_back(pe);
          else q2.push_back(pe);
          acc[i]++;
          hs_seen[i] = 1'b1;
          chk("no_extra_beat", acc[i] <= lay_len[i], $sformatf("ch%0d beat %0d", i, acc[i]),
              $sformatf("<= %0d", lay_len[i]));
        end
      end
    end
  end

  // Drive channel valids/data and GB ready for the current cycle.
  task automatic drive();
    for (int i = 0; i < NUM_CH; i++) begin
      if (hs_seen[i]) begin
        cur_val[i] = 1'b0;
        hs_seen[i] = 1'b0;
      end
      if (!cur_val[i] && vmask[i] && !(drop_after && acc[i] >= lay_len[i]) &&
          (int'($urandom_range(99)) < val_prob)) begin
        cur_val[i] = 1'b1;
        cur_data[i] = rand_beat();
      end
    end
    psum_val = cur_val;
    for (int i = 0; i < NUM_CH; i++) psum_data[i*BEAT_W +: BEAT_W] = cur_data[i];
    if (kcyc >= stall_start && kcyc < stall_start + stall_len) gb_rdy = 1'b0;
    else gb_rdy = (int'($urandom_range(99)) < rdy_prob);
    kcyc++;
  endtask

  // Run one layer from t_base/t_len; abort_after>0 stops early without waiting for done.
  task automatic run_layer(input bit [NUM_CH-1:0] vm, input int vp, input int rp,
                           input int ss, input int sl, input bit da, input int abort_after);
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) begin
      lay_base[i] = t_base[i];
      lay_len[i] = t_len[i];
      acc[i] = 0;
      hs_seen[i] = 1'b0;
      cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(t_base[i]);
      cfg_len[i*LEN_WIDTH +: LEN_WIDTH] = LEN_WIDTH'(t_len[i]);
    end
    q0.delete(); q1.delete(); q2.delete(); ch_log.delete();
    cur_val = '0;
    cyc = 0; busy_cyc = 0; done_cyc = 0; gbval_cyc = 0;
    first_val = -1; last_val = -1; done_at = -1; done_seen = 1'b0; prev_stall = 1'b0;
    vmask = vm; val_prob = vp; rdy_prob = rp; stall_start = ss; stall_len = sl;
    drop_after = da; kcyc = 0;
    start = 1'b1;
    mon_en = 1'b1;
    drive();
    for (int n = 0; n < 3000 && !done_seen && (abort_after == 0 || n < abort_after); n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive();
    end
    start = 1'b0;
    if (abort_after == 0) begin
      chk("done_reached", done_seen, "no done", "done within budget");
      for (int i = 0; i < NUM_CH; i++)
        chk("beats_per_ch", acc[i] == lay_len[i], $sformatf("ch%0d %0d", i, acc[i]),
            $sformatf("%0d", lay_len[i]));
      chk("sb_drained", q0.size() + q1.size() + q2.size() == 0,
          $sformatf("%0d left", q0.size() + q1.size() + q2.size()), "0 left");
      cur_val = '0;
      psum_val = '0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, psum_rdy == '0 && !gb_val && gb_data == '0 && gb_addr == '0 && gb_ch == '0 && !busy && !done,
        $sformatf("rdy=%b val=%0d addr=%0d ch=%0d busy=%0d done=%0d", psum_rdy, gb_val, gb_addr, gb_ch, busy, done),
        "all zero");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
`ifdef PSUM_GB_ARB_STAT_EN
    chk("reset_stat", stat_stall == '0, $sformatf("%h", stat_stall), "0");
`endif
    rst_n = 1'b1;

    // 1: all channels, round-robin order and address interleave
    t_base = '{0, 100, 200}; t_len = '{4, 4, 4};
    run_layer(3'b111, 100, 100, 0, 0, 1'b1, 0);
    chk("t1_beats", ch_log.size() == 12, $sformatf("%0d", ch_log.size()), "12");
    for (int k = 0; k < 12 && k < ch_log.size(); k++)
      chk("t1_rr_order", ch_log[k] == k % 3, $sformatf("beat%0d ch%0d", k, ch_log[k]), $sformatf("ch%0d", k % 3));
    chk("t1_done_timing", done_at - last_val == 2, $sformatf("%0d", done_at - last_val), "2");

    // 2: single channel at full throughput
    t_base = '{0, 37, 0}; t_len = '{0, 8, 0};
    run_layer(3'b010, 100, 100, 0, 0, 1'b1, 0);
    chk("t2_count", gbval_cyc == 8, $sformatf("%0d", gbval_cyc), "8");
    chk("t2_back_to_back", last_val - first_val == 7, $sformatf("%0d", last_val - first_val), "7");

    // 3: GB stalls five cycles mid-stream
    t_base = '{10, 300, 600}; t_len = '{6, 6, 6};
    run_layer(3'b111, 100, 100, 4, 5, 1'b1, 0);
    chk("t3_count", gbval_cyc == 18 + 5, $sformatf("%0d", gbval_cyc), "23");

    // 4: zero-length layer
    t_base = '{1, 2, 3}; t_len = '{0, 0, 0};
    run_layer(3'b111, 100, 100, 0, 0, 1'b0, 0);
    chk("t4_busy", busy_cyc == 3, $sformatf("%0d", busy_cyc), "3");
    chk("t4_done_pulse", done_cyc == 1, $sformatf("%0d", done_cyc), "1");
    chk("t4_no_write", gbval_cyc == 0, $sformatf("%0d", gbval_cyc), "0");

    // 5: address wrap
    t_base = '{1020, 0, 0}; t_len = '{8, 0, 0};
    run_layer(3'b001, 80, 70, 0, 0, 1'b1, 0);
    chk("t5_count", ch_log.size() == 8, $sformatf("%0d", ch_log.size()), "8");

`ifdef PSUM_GB_ARB_STAT_EN
    // stall counter: one channel held off for five cycles
    t_base = '{0, 0, 0}; t_len = '{4, 0, 0};
    run_layer(3'b001, 100, 100, 2, 5, 1'b1, 0);
    chk("stat_ch0", stat_stall[15:0] == 16'd5, $sformatf("%0d", stat_stall[15:0]), "5");
    chk("stat_ch12", stat_stall[47:16] == 32'd0, $sformatf("%h", stat_stall[47:16]), "0");
`endif

    // randomized layers, including channels that keep offering data past their length
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        t_base[i] = int'($urandom_range(1023));
        t_len[i] = int'($urandom_range(12));
      end
      run_layer(3'b111, 30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
                int'($urandom_range(20)), int'($urandom_range(6)), bit'($urandom_range(1)), 0);
    end

    // 6: async reset mid-layer, then a fresh layer
    t_base = '{5, 50, 500}; t_len = '{10, 10, 10};
    run_layer(3'b111, 100, 50, 0, 0, 1'b1, 7);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midlayer_reset");
`ifdef PSUM_GB_ARB_STAT_EN
    chk("midlayer_reset_stat", stat_stall == '0, $sformatf("%h", stat_stall), "0");
`endif
    cur_val = '0;
    psum_val = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    t_base = '{7, 70, 700}; t_len = '{3, 5, 2};
    run_layer(3'b111, 90, 90, 0, 0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
